// File: rtl/nn_stream_pkg.sv
// rtl/nn_stream_pkg.sv - shared types and helpers for the nn stream stages
package nn_stream_pkg;

    // Default sample width shared by the conv and pool stages.
    localparam int unsigned DATA_W = 32;

    typedef logic signed [DATA_W-1:0] data_t;

    // Counter width able to hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo2_stream.sv
// rtl/fifo2_stream.sv - two-entry first-word-fall-through FIFO
module fifo2_stream #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;

    // Next-state: head always holds the oldest entry, tail the younger one.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = push_data_i;
                end else begin
                    tail_d = push_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/relu_maxpool_28_2_32.sv
// rtl/relu_maxpool_28_2_32.sv - ReLU plus non-overlapping 1-D max-pool stream stage
module relu_maxpool_28_2_32
    import nn_stream_pkg::*;
#(
    parameter int L    = 28,
    parameter int W    = 2,
    parameter int T    = DATA_W,
    parameter int RELU = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [T-1:0] s_data_in_x,
    input  logic                s_valid_x,
    output logic                s_ready_x,
    output logic signed [T-1:0] m_data_out_y,
    output logic                m_valid_y,
    input  logic                m_ready_y
);

    localparam int NUMOUT = L / W;
    localparam int WW     = cnt_width(W);
    localparam int PW     = cnt_width(L + 1);

    localparam logic [WW-1:0] WIN_LAST = WW'(W - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(L - 1);
    // Positions at or beyond this index belong to a discarded partial window.
    localparam logic [PW-1:0] POS_FULL = PW'(NUMOUT * W);

    logic [WW-1:0]       win_cnt_q, win_cnt_d;
    logic [PW-1:0]       pos_cnt_q, pos_cnt_d;
    logic signed [T-1:0] run_max_q, run_max_d;

    logic                in_fire;
    logic                out_fire;
    logic signed [T-1:0] cand;
    logic signed [T-1:0] pooled;
    logic                push;
    logic [1:0]          fifo_count;
    logic [T-1:0]        fifo_head;

    assign in_fire  = s_valid_x && s_ready_x;
    assign out_fire = m_valid_y && m_ready_y;

    // First element of a window starts the running max; later ones compare signed.
    assign cand   = (win_cnt_q == '0) ? s_data_in_x
                  : ((s_data_in_x > run_max_q) ? s_data_in_x : run_max_q);
    assign pooled = ((RELU != 0) && cand[T-1]) ? '0 : cand;

    // Window / position bookkeeping for each accepted sample.
    always_comb begin
        win_cnt_d = win_cnt_q;
        pos_cnt_d = pos_cnt_q;
        run_max_d = run_max_q;
        push      = 1'b0;
        if (in_fire) begin
            if (win_cnt_q == WIN_LAST) begin
                push      = (pos_cnt_q < POS_FULL);
                win_cnt_d = '0;
            end else begin
                run_max_d = cand;
                win_cnt_d = win_cnt_q + WW'(1);
            end
            if (pos_cnt_q == POS_LAST) begin
                pos_cnt_d = '0;
                win_cnt_d = '0;
            end else begin
                pos_cnt_d = pos_cnt_q + PW'(1);
            end
        end
    end

    // Window state registers; reset discards any partial vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt_q <= '0;
            pos_cnt_q <= '0;
            run_max_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            pos_cnt_q <= pos_cnt_d;
            run_max_q <= run_max_d;
        end
    end

    fifo2_stream #(
        .WIDTH (T)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .push_data_i (pooled),
        .pop_i       (out_fire),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    // Ready depends only on FIFO occupancy, never on m_ready_y.
    assign s_ready_x    = (fifo_count != 2'd2);
    assign m_valid_y    = (fifo_count != 2'd0);
    assign m_data_out_y = fifo_head;

endmodule

// File: tb/tb_relu_maxpool_28_2_32.sv
// tb/tb_relu_maxpool_28_2_32.sv - self-checking bench for relu_maxpool_28_2_32
module tb_relu_maxpool_28_2_32;

    localparam int L = 28;
    localparam int W = 2;
    localparam int NUMOUT = L / W;

    logic        clk;
    logic        reset;
    logic [31:0] s_data_in_x;
    logic        s_valid_x;
    logic        m_ready_y;

    logic        s_ready1, m_valid1;
    logic [31:0] m_data1;
    logic        s_ready0, m_valid0;
    logic [31:0] m_data0;

    int tests = 0;
    int fails = 0;

    int          cur[$];
    logic [31:0] exp1[$];
    logic [31:0] exp0[$];
    logic [31:0] got1[$];
    logic [31:0] got0[$];

    logic [31:0] dir_in[8]  = '{32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd4,
                                32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0001};
    logic [31:0] dir_r1[4]  = '{32'd0, 32'd4, 32'h7FFF_FFFF, 32'd0};
    logic [31:0] dir_r0[4]  = '{32'hFFFF_FFFD, 32'd4, 32'h7FFF_FFFF, 32'h8000_0001};
    logic [31:0] rnd[84];

    relu_maxpool_28_2_32 #(.L(L), .W(W), .T(32), .RELU(1)) u_dut_r1 (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_x  (s_data_in_x),
        .s_valid_x    (s_valid_x),
        .s_ready_x    (s_ready1),
        .m_data_out_y (m_data1),
        .m_valid_y    (m_valid1),
        .m_ready_y    (m_ready_y)
    );

    relu_maxpool_28_2_32 #(.L(L), .W(W), .T(32), .RELU(0)) u_dut_r0 (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_x  (s_data_in_x),
        .s_valid_x    (s_valid_x),
        .s_ready_x    (s_ready0),
        .m_data_out_y (m_data0),
        .m_valid_y    (m_valid0),
        .m_ready_y    (m_ready_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: collect a vector, emit max of each complete pair.
    task automatic model_accept(input logic [31:0] x);
        int n, a, b, m;
        cur.push_back(int'(x));
        n = cur.size();
        if ((n % W) == 0 && n <= NUMOUT * W) begin
            a = cur[n-2];
            b = cur[n-1];
            m = (a > b) ? a : b;
            exp0.push_back(32'(m));
            exp1.push_back((m < 0) ? 32'd0 : 32'(m));
        end
        if (n == L) cur.delete();
    endtask

    task automatic cyc(input bit v, input logic [31:0] d, input bit mr, output bit acc);
        bit exp_ready;
        @(negedge clk);
        s_valid_x   = v;
        s_data_in_x = v ? d : 'x;
        m_ready_y   = mr;
        #1;
        exp_ready = (exp1.size() < 2);
        chk("s_ready_r1", 32'(s_ready1), 32'(exp_ready));
        chk("s_ready_r0", 32'(s_ready0), 32'(exp_ready));
        chk("m_valid_r1", 32'(m_valid1), 32'(exp1.size() != 0));
        chk("m_valid_r0", 32'(m_valid0), 32'(exp0.size() != 0));
        if (mr && exp1.size() != 0) begin
            chk("data_r1", m_data1, exp1[0]);
            chk("data_r0", m_data0, exp0[0]);
            got1.push_back(m_data1);
            got0.push_back(m_data0);
            void'(exp1.pop_front());
            void'(exp0.pop_front());
        end
        acc = v && exp_ready;
        if (acc) model_accept(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        #1;
        chk("rst_valid_r1", 32'(m_valid1), 32'd0);
        chk("rst_data_r1", m_data1, 32'd0);
        chk("rst_valid_r0", 32'(m_valid0), 32'd0);
        chk("rst_data_r0", m_data0, 32'd0);
        exp1.delete();
        exp0.delete();
        cur.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_ready_r1", 32'(s_ready1), 32'd1);
        chk("rst_ready_r0", 32'(s_ready0), 32'd1);
    endtask

    initial begin
        bit acc;
        int i;
        int idx;
        int drop;
        reset       = 1'b0;
        s_valid_x   = 1'b0;
        s_data_in_x = '0;
        m_ready_y   = 1'b0;

        // Plain stream 1..28 at full rate.
        do_reset();
        got1.delete(); got0.delete();
        for (int k = 1; k <= L; k++) cyc(1'b1, 32'(k), 1'b1, acc);
        repeat (4) cyc(1'b0, 32'd0, 1'b1, acc);
        chk("stream_count", 32'(got1.size()), 32'd14);
        for (int k = 0; k < got1.size(); k++) chk("stream_val", got1[k], 32'(2 * (k + 1)));

        // Directed sign and extreme-value pairs.
        do_reset();
        got1.delete(); got0.delete();
        for (int k = 0; k < 8; k++) cyc(1'b1, dir_in[k], 1'b1, acc);
        repeat (3) cyc(1'b0, 32'd0, 1'b1, acc);
        chk("dir_count", 32'(got1.size()), 32'd4);
        for (int k = 0; k < 4 && k < got1.size(); k++) begin
            chk("dir_relu1", got1[k], dir_r1[k]);
            chk("dir_relu0", got0[k], dir_r0[k]);
        end

        // Output stalled for 20 cycles while streaming.
        do_reset();
        got1.delete(); got0.delete();
        i = 1;
        drop = -1;
        for (int c = 0; c < 300 && (i <= L || exp1.size() != 0); c++) begin
            cyc(i <= L, 32'(i), c >= 20, acc);
            if (!s_ready1 && drop < 0) drop = i - 1;
            if (acc) i++;
        end
        chk("bp_drop_after", 32'(drop), 32'd4);
        chk("bp_all_in", 32'(i), 32'(L + 1));
        chk("bp_count", 32'(got1.size()), 32'd14);
        for (int k = 0; k < got1.size(); k++) chk("bp_val", got1[k], 32'(2 * (k + 1)));

        // Random handshakes over three vectors of random signed data.
        do_reset();
        got1.delete(); got0.delete();
        for (int k = 0; k < 84; k++) rnd[k] = $urandom;
        idx = 0;
        for (int c = 0; c < 3000 && (idx < 84 || exp1.size() != 0); c++) begin
            cyc(($urandom_range(0, 1) == 1) && idx < 84, (idx < 84) ? rnd[idx] : 32'd0,
                $urandom_range(0, 1) == 1, acc);
            if (acc) idx++;
        end
        chk("rnd_all_in", 32'(idx), 32'd84);
        chk("rnd_count", 32'(got1.size()), 32'd42);

        // Reset mid-vector, then a fresh vector.
        do_reset();
        for (int k = 1; k <= 7; k++) cyc(1'b1, 32'(k), 1'b1, acc);
        do_reset();
        got1.delete(); got0.delete();
        for (int k = 1; k <= L; k++) cyc(1'b1, 32'(10 * k), 1'b1, acc);
        repeat (4) cyc(1'b0, 32'd0, 1'b1, acc);
        chk("mid_count", 32'(got1.size()), 32'd14);
        for (int k = 0; k < got1.size(); k++) begin
            chk("mid_val_r1", got1[k], 32'(20 * (k + 1)));
            chk("mid_val_r0", got0[k], 32'(20 * (k + 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
